// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared states, length codes and helpers for the byte-serial memory controller
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b11;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // Code 2'b10 falls into the word case on purpose.
    function automatic logic [2:0] byte_count(input logic [1:0] len);
        case (len)
            LEN_BYTE: return 3'd1;
            LEN_HALF: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] len_mask(input logic [1:0] len);
        case (len)
            LEN_BYTE: return 32'h0000_00FF;
            LEN_HALF: return 32'h0000_FFFF;
            default:  return 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_pack.sv
// rtl/mem_byte_pack.sv - assembles RAM read bytes into a little-endian word, zero-extended by length
module mem_byte_pack
    import mem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        cap_en,
    input  logic [1:0]  lane,
    input  logic [7:0]  din,
    input  logic [1:0]  len,
    output logic [31:0] data_next
);

    logic [31:0] lanes_q;
    logic [31:0] lanes_ins;

    always_comb begin
        lanes_ins = lanes_q;
        lanes_ins[{lane, 3'b000} +: 8] = din;
    end

    // Includes the byte being captured this cycle so the final lane is visible at completion.
    assign data_next = (cap_en ? lanes_ins : lanes_q) & len_mask(len);

    always_ff @(posedge clk) begin
        if (!rst) begin
            lanes_q <= 32'h0;
        end else if (clr) begin
            lanes_q <= 32'h0;
        end else if (cap_en) begin
            lanes_q <= lanes_ins;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - arbitrates IF and MEM requests onto a single byte-wide synchronous RAM port
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_inst,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_len,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    output logic [31:0] ram_addr_o,
    output logic        ram_wr_o,
    output logic [7:0]  ram_dout_o,
    input  logic [7:0]  ram_din_i
);

    state_t      state, state_nxt;
    owner_t      owner;
    logic [2:0]  cnt;
    logic [2:0]  nbytes;
    logic        we_q;
    logic [1:0]  len_q;
    logic [31:0] wdata_q;
    logic        rdy_q;
    logic [7:0]  din_hold;
    logic [7:0]  din_sel;
    logic        last_busy;
    logic        grant;
    logic        cap_en;
    logic [31:0] data_next;

    assign nbytes    = byte_count(len_q);
    assign last_busy = (state == ST_BUSY) && (we_q ? (cnt == nbytes - 3'd1) : (cnt == nbytes));
    assign grant     = (state == ST_IDLE) && (if_req || mem_req);
    assign cap_en    = rdy && (state == ST_BUSY) && !we_q && (cnt != 3'd0);

    // The RAM keeps reading the held address during a stall, so the byte due at the
    // first frozen edge is parked and replayed on resume.
    assign din_sel = rdy_q ? ram_din_i : din_hold;

    mem_byte_pack u_pack (
        .clk       (clk),
        .rst       (rst),
        .clr       (rdy && grant),
        .cap_en    (cap_en),
        .lane      (cnt[1:0] - 2'd1),
        .din       (din_sel),
        .len       (len_q),
        .data_next (data_next)
    );

    always_comb begin
        state_nxt  = state;
        if_done    = DISABLE;
        mem_done   = DISABLE;
        ram_wr_o   = DISABLE;
        ram_dout_o = 8'h00;
        case (state)
            ST_IDLE: if (grant) state_nxt = ST_BUSY;
            ST_BUSY: if (last_busy) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (state == ST_BUSY && we_q) begin
            ram_dout_o = wdata_q[{cnt[1:0], 3'b000} +: 8];
            ram_wr_o   = rdy;
        end
        if (state == ST_DONE && rdy) begin
            if (owner == OWN_IF) if_done  = ENABLE;
            else                 mem_done = ENABLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= 3'd0;
            owner      <= OWN_IF;
            we_q       <= DISABLE;
            len_q      <= LEN_WORD;
            wdata_q    <= 32'h0;
            ram_addr_o <= 32'h0;
            if_inst    <= 32'h0;
            mem_rdata  <= 32'h0;
            rdy_q      <= ENABLE;
            din_hold   <= 8'h00;
        end else begin
            rdy_q <= rdy;
            if (!rdy && rdy_q) din_hold <= ram_din_i;
            if (rdy) begin
                state <= state_nxt;
                case (state)
                    ST_IDLE: begin
                        cnt <= 3'd0;
                        if (mem_req) begin
                            owner      <= OWN_MEM;
                            we_q       <= mem_we;
                            len_q      <= mem_len;
                            wdata_q    <= mem_wdata;
                            ram_addr_o <= mem_addr;
                        end else if (if_req) begin
                            owner      <= OWN_IF;
                            we_q       <= DISABLE;
                            len_q      <= LEN_WORD;
                            ram_addr_o <= if_addr;
                        end
                    end
                    ST_BUSY: begin
                        cnt <= cnt + 3'd1;
                        if (cnt + 3'd1 < nbytes) ram_addr_o <= ram_addr_o + 32'd1;
                        if (last_busy && !we_q) begin
                            if (owner == OWN_IF) if_inst   <= data_next;
                            else                 mem_rdata <= data_next;
                        end
                    end
                    default: cnt <= 3'd0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - scoreboard bench for mem_ctrl with a byte-wide synchronous RAM model
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    typedef struct {
        bit          is_write;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        if_done;
    logic [31:0] if_inst;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [1:0]  mem_len = 2'b00;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic [31:0] ram_addr_o;
    logic        ram_wr_o;
    logic [7:0]  ram_dout_o;
    logic [7:0]  ram_din_i = 8'h00;

    logic [7:0]  ram [0:1023];
    logic [31:0] if_exp[$];
    exp_t        mem_exp[$];
    logic [39:0] wr_seen[$];
    logic [31:0] trace [0:15];
    int          checks = 0;
    int          errors = 0;

    mem_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_done    (if_done),
        .if_inst    (if_inst),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_len    (mem_len),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_done   (mem_done),
        .mem_rdata  (mem_rdata),
        .ram_addr_o (ram_addr_o),
        .ram_wr_o   (ram_wr_o),
        .ram_dout_o (ram_dout_o),
        .ram_din_i  (ram_din_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ram_din_i <= ram[ram_addr_o[9:0]];
        if (ram_wr_o) ram[ram_addr_o[9:0]] <= ram_dout_o;
    end

    always @(negedge clk) begin : monitor
        logic [31:0] ei;
        exp_t        em;
        if (ram_wr_o === 1'b1) wr_seen.push_back({ram_addr_o, ram_dout_o});
        if (if_done === 1'b1) begin
            checks++;
            if (if_exp.size() == 0) begin
                errors++;
                $display("FAIL if_done_unexpected: got pulse with if_inst=%h, expected no pulse", if_inst);
            end else begin
                ei = if_exp.pop_front();
                if (if_inst !== ei) begin
                    errors++;
                    $display("FAIL if_inst: got %h, expected %h", if_inst, ei);
                end
            end
        end
        if (mem_done === 1'b1) begin
            checks++;
            if (mem_exp.size() == 0) begin
                errors++;
                $display("FAIL mem_done_unexpected: got pulse, expected no pulse");
            end else begin
                em = mem_exp.pop_front();
                if (!em.is_write && mem_rdata !== em.data) begin
                    errors++;
                    $display("FAIL mem_rdata: got %h, expected %h", mem_rdata, em.data);
                end
            end
        end
    end

    // Starts at a negedge; lat = index of the edge after which done was seen (edge 0 samples the request).
    task automatic do_txn(input bit is_if, input bit we, input logic [1:0] len,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int stall_at, input int rst_at, output int lat);
        lat = -1;
        if (is_if) begin
            if_req  = 1'b1;
            if_addr = addr;
        end else begin
            mem_req   = 1'b1;
            mem_we    = we;
            mem_len   = len;
            mem_addr  = addr;
            mem_wdata = wdata;
        end
        for (int e = 0; e < 40; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e < 16) trace[e] = ram_addr_o;
            if (is_if ? if_done : mem_done) begin
                lat = e;
                break;
            end
            if (e == stall_at) rdy = 1'b0;
            if (e == stall_at + 3) rdy = 1'b1;
            if (rst_at >= 0 && e == rst_at) begin
                rst     = 1'b0;
                if_req  = 1'b0;
                mem_req = 1'b0;
            end else if (rst_at >= 0 && e == rst_at + 1) begin
                rst = 1'b1;
                lat = e;
                break;
            end
        end
        if (is_if) if_req = 1'b0;
        else       mem_req = 1'b0;
        if (rst_at < 0) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({if_done, mem_done, ram_wr_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_strobes: got %b, expected 000", {if_done, mem_done, ram_wr_o});
        end
        checks++;
        if ({ram_addr_o, ram_dout_o} !== 40'h0) begin
            errors++;
            $display("FAIL reset_ram_port: got addr %h dout %h, expected 0", ram_addr_o, ram_dout_o);
        end
        checks++;
        if ({if_inst, mem_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: got if_inst %h mem_rdata %h, expected 0", if_inst, mem_rdata);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_if_read();
        int lat;
        if_exp.push_back(32'h9300_0013);
        do_txn(1'b1, 1'b0, LEN_WORD, 32'h10, 32'h0, -1, -1, lat);
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL if_latency: got %0d, expected 5", lat);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (trace[k] !== 32'h10 + k) begin
                errors++;
                $display("FAIL if_addr_seq[%0d]: got %h, expected %h", k, trace[k], 32'h10 + k);
            end
        end
    endtask

    task automatic test_priority();
        int lat;
        if_req  = 1'b1;
        if_addr = 32'h10;
        if_exp.push_back(32'h9300_0013);
        mem_exp.push_back('{is_write: 1'b0, data: 32'h0000_00FF});
        do_txn(1'b0, 1'b0, LEN_BYTE, 32'h20, 32'h0, -1, -1, lat);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL prio_mem_latency: got %0d, expected 2", lat);
        end
        checks++;
        if (if_exp.size() !== 1) begin
            errors++;
            $display("FAIL prio_if_pending: got %0d queued, expected 1", if_exp.size());
        end
        do_txn(1'b1, 1'b0, LEN_WORD, 32'h10, 32'h0, -1, -1, lat);
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL prio_if_latency: got %0d, expected 5", lat);
        end
    endtask

    task automatic test_word_write();
        int lat;
        logic [7:0] exp_b [0:3];
        exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        wr_seen.delete();
        mem_exp.push_back('{is_write: 1'b1, data: 32'h0});
        do_txn(1'b0, 1'b1, LEN_WORD, 32'h100, 32'hDEAD_BEEF, -1, -1, lat);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL write_latency: got %0d, expected 4", lat);
        end
        checks++;
        if (wr_seen.size() !== 4) begin
            errors++;
            $display("FAIL write_count: got %0d, expected 4", wr_seen.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (wr_seen[k] !== {32'h100 + k, exp_b[k]}) begin
                    errors++;
                    $display("FAIL write_byte[%0d]: got %h, expected %h", k, wr_seen[k], {32'h100 + k, exp_b[k]});
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        mem_exp.push_back('{is_write: 1'b0, data: 32'hDEAD_BEEF});
        do_txn(1'b0, 1'b0, LEN_WORD, 32'h100, 32'h0, -1, -1, lat);
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL readback_latency: got %0d, expected 5", lat);
        end
        mem_exp.push_back('{is_write: 1'b0, data: 32'h0000_00FF});
        do_txn(1'b0, 1'b0, LEN_BYTE, 32'h20, 32'h0, -1, -1, lat);
        mem_exp.push_back('{is_write: 1'b0, data: 32'h9300_0013});
        do_txn(1'b0, 1'b0, 2'b10, 32'h10, 32'h0, -1, -1, lat);
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL len10_latency: got %0d, expected 5", lat);
        end
    endtask

    task automatic test_wrap();
        int lat;
        mem_exp.push_back('{is_write: 1'b0, data: 32'h0000_CDAB});
        do_txn(1'b0, 1'b0, LEN_HALF, 32'hFFFF_FFFF, 32'h0, -1, -1, lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL wrap_latency: got %0d, expected 3", lat);
        end
        checks++;
        if (trace[0] !== 32'hFFFF_FFFF || trace[1] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addr: got %h,%h, expected ffffffff,00000000", trace[0], trace[1]);
        end
    endtask

    task automatic test_stall();
        int lat;
        wr_seen.delete();
        if_exp.push_back(32'h9300_0013);
        do_txn(1'b1, 1'b0, LEN_WORD, 32'h10, 32'h0, 2, -1, lat);
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL stall_latency: got %0d, expected 8", lat);
        end
        for (int k = 3; k < 6; k++) begin
            checks++;
            if (trace[k] !== 32'h12) begin
                errors++;
                $display("FAIL stall_addr[%0d]: got %h, expected 00000012", k, trace[k]);
            end
        end
        checks++;
        if (wr_seen.size() !== 0 || mem_rdata !== 32'h0000_CDAB) begin
            errors++;
            $display("FAIL stall_side_effects: got %0d writes, mem_rdata %h, expected 0 writes, 0000cdab",
                     wr_seen.size(), mem_rdata);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        wr_seen.delete();
        do_txn(1'b0, 1'b1, LEN_WORD, 32'h200, 32'h1122_3344, -1, 1, lat);
        checks++;
        if (ram_wr_o !== 1'b0 || mem_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_strobes: got wr %b done %b, expected 0 0", ram_wr_o, mem_done);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (wr_seen.size() !== 2) begin
            errors++;
            $display("FAIL abort_write_count: got %0d, expected 2", wr_seen.size());
        end
        if_exp.push_back(32'h9300_0013);
        do_txn(1'b1, 1'b0, LEN_WORD, 32'h10, 32'h0, -1, -1, lat);
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL after_abort_latency: got %0d, expected 5", lat);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[10'h010] = 8'h13;
        ram[10'h011] = 8'h00;
        ram[10'h012] = 8'h00;
        ram[10'h013] = 8'h93;
        ram[10'h020] = 8'hFF;
        ram[10'h3FF] = 8'hAB;
        ram[10'h000] = 8'hCD;
        test_reset();
        test_if_read();
        test_priority();
        test_word_write();
        test_back_to_back();
        test_wrap();
        test_stall();
        test_reset_mid();
        repeat (3) @(negedge clk);
        checks++;
        if (if_exp.size() !== 0 || mem_exp.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d if / %0d mem pending, expected 0",
                     if_exp.size(), mem_exp.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
